tm_infer_seq: RTL and testbench
===============================

# tm_infer_seq

Parametrised sequencing and classification controller for Tsetlin-machine inference. It accepts one datapoint as `PACKETS_NUM` AXI-Stream beats and steers each beat into the hard-coded clause pipeline with a one-hot packet strobe. It then starts the class-sum adder, performs a sequential argmax over `CLASS_NUM` signed sums, and returns the class index on an AXI-Stream master with full backpressure and `tlast` propagation. It replaces the fixed 10-class, fixed 13-packet control path and adds reset, input flow control and output backpressure.

## Interface
- `PACKETS_NUM`, 13: beats per datapoint, ≥1.
- `CLASS_NUM`, 10: number of classes, ≥2.
- `WEIGHT_LENGTH`, 16: signed class-sum width.
- `C_M00_AXIS_TDATA_WIDTH`, 32: output data width, ≥ $clog2(CLASS_NUM).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat accepted when high with `tvalid`.
- `s_axis_tlast` in 1: end-of-stream marker from the DMA.
- `pkt_valid` out PACKETS_NUM: one-hot strobe to the clause pipeline; bit i marks packet i.
- `adder_start` out 1: one-cycle pulse that starts the class-sum adder.
- `adder_done` in 1: adder finished; `class_sums` is valid in this cycle.
- `class_sums` in CLASS_NUM*WEIGHT_LENGTH: flattened signed sums; class k is at [k*WEIGHT_LENGTH +: WEIGHT_LENGTH].
- `m_axis_tvalid` out 1: result valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out C_M00_AXIS_TDATA_WIDTH: winning class index, zero-extended.
- `m_axis_tlast` out 1: marks the result of the datapoint that carried `tlast`.
- `busy` out 1: high in every state except LOAD.

## Operation
- FSM states: LOAD → ADD → ARGMAX → OUT → LOAD.
- LOAD:
  - `s_axis_tready`=1.
  - On a handshake, `pkt_valid[pkt_cnt]`=1 in the same cycle (combinational from the handshake), then `pkt_cnt` increments.
  - On the handshake with `pkt_cnt`=PACKETS_NUM-1, `pkt_cnt` wraps to 0 and the FSM moves to ADD.
  - `s_axis_tlast` on any accepted beat sets the sticky flag `last_q`.
- ADD:
  - `adder_start` pulses on the first ADD cycle only.
  - The FSM waits for `adder_done`.
  - When `adder_done` is seen, `class_sums` is registered into `sums_q`, `best_idx`=0, `best_val`=sum[0], `scan`=1, and the FSM moves to ARGMAX.
  - `adder_done` is ignored outside ADD.
- ARGMAX:
  - One comparison per cycle: if sum[scan] > `best_val` (signed, strict), update `best_idx` and `best_val`.
  - After scan=CLASS_NUM-1 is evaluated, the FSM moves to OUT.
  - Ties resolve to the lowest index.
- OUT:
  - `m_axis_tvalid`=1, `m_axis_tdata`=`best_idx`, `m_axis_tlast`=`last_q`.
  - All three are held stable until `m_axis_tready`.
  - On the handshake: clear `last_q`, drop `tvalid`, return to LOAD.
- `s_axis_tready`=0 in ADD, ARGMAX and OUT. Input is never dropped; the upstream stalls.
- Reset, at any time including mid-datapoint or mid-OUT:
  - state=LOAD, `pkt_cnt`=0, `last_q`=0, `sums_q`/`best_*`=0.
  - A partially loaded datapoint is discarded.

## Timing
- Output values while `rst` is high: `s_axis_tready`=0, `pkt_valid`=0, `adder_start`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `busy`=0.
- `s_axis_tready`=1 from the first cycle after `rst` falls.
- Final beat accepted in cycle t → `adder_start`=1 in cycle t+1 → `busy`=1 from t+1.
- `adder_done` in cycle d → ARGMAX spans d+1 … d+CLASS_NUM-1 → `m_axis_tvalid`=1 from cycle d+CLASS_NUM.
- Output handshake in cycle h → `s_axis_tready`=1 in h+1. There is no overlap between datapoints.
- `adder_done` arriving in the same cycle as `adder_start` (0-cycle adder) is accepted.
- `pkt_valid` is never asserted without a completed input handshake.
- For PACKETS_NUM=1, every accepted beat goes to ADD.

## Test plan
- Reset then one datapoint: PACKETS_NUM=13, 13 back-to-back beats → `pkt_valid` walks 0x0001…0x1000. `adder_start` fires exactly once, one cycle after beat 13. Stub `adder_done` 3 cycles later with sums {5,-2,9,9,0,…} → `tdata`=2, `tvalid` high 10 cycles after `adder_done`.
- Backpressure: hold `m_axis_tready`=0 for 20 cycles → `tvalid`, `tdata` and `tlast` stay stable and `s_axis_tready`=0 throughout. Release → `tready`=1 on the next cycle.
- Input gaps: deassert `s_axis_tvalid` randomly → `pkt_cnt` advances only on handshakes. `adder_start` only after the 13th accepted beat.
- `tlast` propagation: two datapoints, `tlast` on the final beat of the second → `m_axis_tlast`=0 for the first result, 1 for the second, and the flag is cleared afterwards.
- All-negative/tie sums: all sums = -7 → index 0. Max at the last class (sum[9]=32767, others -32768) → index 9.
- Mid-operation reset: assert `rst` after 6 beats and again during OUT → all outputs return to their reset values. A fresh 13-beat datapoint then produces a correct result with `pkt_valid` restarting at bit 0.

Source files
------------

// File: rtl/tm_infer_seq.sv
// Tsetlin-machine inference sequencer: packet steering, adder kick-off,
// sequential signed argmax and AXI-Stream result output.
module tm_infer_seq #(
  parameter int PACKETS_NUM            = 13,
  parameter int CLASS_NUM              = 10,
  parameter int WEIGHT_LENGTH          = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [PACKETS_NUM-1:0]            pkt_valid,
  output logic                              adder_start,
  input  logic                              adder_done,
  input  logic [CLASS_NUM*WEIGHT_LENGTH-1:0] class_sums,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              busy
);

  localparam int CNT_W = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
  localparam int IDX_W = $clog2(CLASS_NUM);
  localparam int SUM_W = CLASS_NUM * WEIGHT_LENGTH;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_ADD    = 2'd1;
  localparam logic [1:0] S_ARGMAX = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic [SUM_W-1:0] sums_q, sums_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W-1:0] scan_q, scan_d;

  logic signed [WEIGHT_LENGTH-1:0] best_val_q, best_val_d;
  logic signed [WEIGHT_LENGTH-1:0] sum_arr [CLASS_NUM];
  logic signed [WEIGHT_LENGTH-1:0] cur_sum;

  logic s_hs;
  logic m_hs;
  logic cnt_end;
  logic scan_end;

  for (genvar k = 0; k < CLASS_NUM; k++) begin : g_unpack
    assign sum_arr[k] = sums_q[k*WEIGHT_LENGTH +: WEIGHT_LENGTH];
  end

  assign cur_sum  = sum_arr[scan_q];
  assign cnt_end  = (pkt_cnt_q == CNT_W'(PACKETS_NUM - 1));
  assign scan_end = (scan_q == IDX_W'(CLASS_NUM - 1));

  // Every output is forced quiet while rst is held, whatever the state.
  assign s_axis_tready = !rst && (state_q == S_LOAD);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign adder_start   = !rst && (state_q == S_ADD) && first_q;
  assign m_axis_tvalid = !rst && (state_q == S_OUT);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && last_q;
  assign busy          = !rst && (state_q != S_LOAD);

  assign m_axis_tdata = m_axis_tvalid
                      ? C_M00_AXIS_TDATA_WIDTH'(best_idx_q)
                      : '0;

  always_comb begin
    pkt_valid = '0;
    for (int i = 0; i < PACKETS_NUM; i++) begin
      pkt_valid[i] = s_hs && (pkt_cnt_q == CNT_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    last_d     = last_q;
    first_d    = first_q;
    sums_d     = sums_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    scan_d     = scan_q;

    unique case (state_q)
      S_LOAD: begin
        if (s_hs) begin
          if (s_axis_tlast) last_d = 1'b1;
          if (cnt_end) begin
            pkt_cnt_d = '0;
            first_d   = 1'b1;
            state_d   = S_ADD;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end
        end
      end
      S_ADD: begin
        first_d = 1'b0;
        if (adder_done) begin
          sums_d     = class_sums;
          best_idx_d = '0;
          best_val_d = class_sums[WEIGHT_LENGTH-1:0];
          scan_d     = IDX_W'(1);
          state_d    = S_ARGMAX;
        end
      end
      S_ARGMAX: begin
        // Strict compare keeps the lowest index on ties.
        if (cur_sum > best_val_q) begin
          best_val_d = cur_sum;
          best_idx_d = scan_q;
        end
        scan_d = scan_q + IDX_W'(1);
        if (scan_end) state_d = S_OUT;
      end
      S_OUT: begin
        if (m_hs) begin
          last_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      pkt_cnt_q  <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
      sums_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      scan_q     <= '0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      last_q     <= last_d;
      first_q    <= first_d;
      sums_q     <= sums_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      scan_q     <= scan_d;
    end
  end

endmodule

// File: tb/tb_tm_infer_seq.sv
// Directed bench for tm_infer_seq: vector table of class sums plus
// hand sequences for backpressure, tlast and mid-operation reset.
module tb_tm_infer_seq;

  localparam int PN = 13;
  localparam int CN = 10;
  localparam int WL = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [PN-1:0]    pkt_valid;
  logic             adder_start;
  logic             adder_done;
  logic [CN*WL-1:0] class_sums;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tlast;
  logic             busy;

  tm_infer_seq #(
    .PACKETS_NUM(PN),
    .CLASS_NUM(CN),
    .WEIGHT_LENGTH(WL),
    .C_M00_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .pkt_valid(pkt_valid),
    .adder_start(adder_start),
    .adder_done(adder_done),
    .class_sums(class_sums),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CN*WL-1:0] sums;
    int               exp_idx;
    int               dly;
    bit               gaps;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CN*WL-1:0] pk(input int s[CN]);
    logic [CN*WL-1:0] r;
    r = '0;
    for (int k = 0; k < CN; k++) r[k*WL +: WL] = s[k][WL-1:0];
    return r;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_pkt_valid"}, pkt_valid, 0);
    chk({tag, "_adder_start"}, adder_start, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic send_beats(input int n, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(2, 0);
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          s_axis_tvalid = 1'b0;
          #1;
          chk("gap_pkt_valid", pkt_valid, 0);
          chk("gap_adder_start", adder_start, 0);
        end
      end
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last && (i == n - 1);
      #1;
      chk("pkt_valid", pkt_valid, 64'(1) << i);
      chk("load_s_tready", s_axis_tready, 1);
      chk("load_busy", busy, 0);
      chk("load_adder_start", adder_start, 0);
    end
  endtask

  task automatic run_result(input logic [CN*WL-1:0] sums, input int dly,
                            input int exp_idx, input bit exp_last);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      adder_done    = (k == dly);
      class_sums    = adder_done ? sums : ~sums;
      #1;
      chk("adder_start", adder_start, (k == 0));
      chk("add_busy", busy, 1);
      chk("add_s_tready", s_axis_tready, 0);
      chk("add_pkt_valid", pkt_valid, 0);
    end
    for (int k = 1; k < CN; k++) begin
      @(negedge clk);
      adder_done = (k == 2);
      class_sums = ~sums;
      #1;
      chk("argmax_m_tvalid", m_axis_tvalid, 0);
      chk("argmax_s_tready", s_axis_tready, 0);
      chk("argmax_adder_start", adder_start, 0);
    end
    @(negedge clk);
    adder_done = 1'b0;
    #1;
    chk("out_m_tvalid", m_axis_tvalid, 1);
    chk("out_m_tdata", m_axis_tdata, exp_idx);
    chk("out_m_tlast", m_axis_tlast, exp_last);
    chk("out_pkt_valid", pkt_valid, 0);
  endtask

  task automatic drain(input int hold, input int exp_idx, input bit exp_last);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      #1;
      chk("bp_m_tvalid", m_axis_tvalid, 1);
      chk("bp_m_tdata", m_axis_tdata, exp_idx);
      chk("bp_m_tlast", m_axis_tlast, exp_last);
      chk("bp_s_tready", s_axis_tready, 0);
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    #1;
    chk("hs_m_tvalid", m_axis_tvalid, 1);
    chk("hs_m_tdata", m_axis_tdata, exp_idx);
    @(negedge clk);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk("post_m_tvalid", m_axis_tvalid, 0);
    chk("post_m_tlast", m_axis_tlast, 0);
    chk("post_s_tready", s_axis_tready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic full_dp(input logic [CN*WL-1:0] sums, input int exp_idx,
                         input int dly, input bit last, input bit gaps,
                         input int hold);
    send_beats(PN, last, gaps);
    run_result(sums, dly, exp_idx, last);
    drain(hold, exp_idx, last);
  endtask

  initial begin
    int tmp[CN];

    tmp = '{5, -2, 9, 9, 0, 0, 0, 0, 0, 0};
    vt[0] = '{pk(tmp), 2, 3, 1'b0};
    tmp = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    vt[1] = '{pk(tmp), 0, 1, 1'b1};
    for (int k = 0; k < CN; k++) tmp[k] = -32768;
    tmp[CN-1] = 32767;
    vt[2] = '{pk(tmp), 9, 0, 1'b0};
    tmp = '{0, 0, 0, 100, 0, 0, 0, 100, 0, 0};
    vt[3] = '{pk(tmp), 3, 2, 1'b1};
    tmp = '{-5, -3, -3, -9, -9, -9, -9, -9, -9, -9};
    vt[4] = '{pk(tmp), 1, 5, 1'b0};
    tmp = '{-32768, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[5] = '{pk(tmp), 4, 0, 1'b1};

    rst           = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    adder_done    = 1'b1;
    class_sums    = '1;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");

    @(negedge clk);
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    adder_done    = 1'b0;
    class_sums    = '0;
    m_axis_tready = 1'b0;
    #1;
    chk("rel_s_tready", s_axis_tready, 1);
    chk("rel_busy", busy, 0);

    full_dp(vt[0].sums, 2, 3, 1'b0, 1'b0, 0);
    full_dp(vt[0].sums, 2, 3, 1'b0, 1'b0, 20);

    for (int v = 0; v < 6; v++) begin
      full_dp(vt[v].sums, vt[v].exp_idx, vt[v].dly, 1'b0, vt[v].gaps, v);
    end

    full_dp(vt[3].sums, 3, 1, 1'b0, 1'b0, 1);
    full_dp(vt[4].sums, 1, 1, 1'b1, 1'b0, 2);
    full_dp(vt[5].sums, 4, 1, 1'b0, 1'b0, 0);

    send_beats(6, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("midload_rst");
    @(negedge clk);
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    chk("midload_rel_s_tready", s_axis_tready, 1);
    full_dp(vt[2].sums, 9, 2, 1'b0, 1'b0, 0);

    send_beats(PN, 1'b1, 1'b0);
    run_result(vt[0].sums, 1, 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("midout_rst");
    @(negedge clk);
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk("midout_rel_s_tready", s_axis_tready, 1);
    chk("midout_rel_busy", busy, 0);
    full_dp(vt[1].sums, 0, 3, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
